sipo_shift_framer: RTL

Parametrised serial-in/parallel-out shift register with bidirectional shifting, parallel load, serial-out tap and frame assembly. It replaces the fixed 8-bit SIPO register as the bit-to-word front end of the datapath. It counts enabled shifts and emits a captured word with a one-cycle valid strobe every WIDTH bits.

---
 rtl/sipo_shift_framer_if.sv | 28 ++
 rtl/sipo_shift_framer.sv | 72 +++++++
 2 files changed

// File: rtl/sipo_shift_framer_if.sv
// Handshake/bus bundle for sipo_shift_framer: serial/parallel inputs, register view and frame outputs.
// master drives the stimulus side; slave is the framer itself.
interface sipo_shift_framer_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             en;
  logic             dir;
  logic             si;
  logic             load;
  logic [WIDTH-1:0] pi;
  logic [WIDTH-1:0] po;
  logic             so;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_valid;
  logic [WIDTH-1:0] frame_data;

  modport master (
    output en, dir, si, load, pi,
    input  po, so, bit_cnt, frame_valid, frame_data
  );

  modport slave (
    input  en, dir, si, load, pi,
    output po, so, bit_cnt, frame_valid, frame_data
  );
endinterface

// File: rtl/sipo_shift_framer.sv
// Bidirectional SIPO shift register with parallel load and serial-out tap.
// It assembles a word every WIDTH enabled shifts and emits it with a one-cycle valid strobe.
module sipo_shift_framer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  sipo_shift_framer_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] po_q, po_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             frame_valid_q, frame_valid_d;
  logic [WIDTH-1:0] frame_data_q, frame_data_d;
  logic [WIDTH-1:0] shifted;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             to_lsb,
                                                input logic             bit_in);
    if (to_lsb) begin
      shift_in = {bit_in, cur[WIDTH-1:1]};
    end else begin
      shift_in = {cur[WIDTH-2:0], bit_in};
    end
  endfunction

  always_comb begin
    shifted       = shift_in(po_q, bus.dir, bus.si);
    po_d          = po_q;
    bit_cnt_d     = bit_cnt_q;
    frame_valid_d = 1'b0;
    frame_data_d  = frame_data_q;
    // Load wins over shift and throws away any partially assembled frame.
    if (bus.load) begin
      po_d      = bus.pi;
      bit_cnt_d = '0;
    end else if (bus.en) begin
      po_d = shifted;
      if (bit_cnt_q == CNT_LAST) begin
        bit_cnt_d     = '0;
        frame_valid_d = 1'b1;
        frame_data_d  = shifted;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      po_q          <= RESET_VAL;
      bit_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
    end else begin
      po_q          <= po_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
    end
  end

  // The tap is the bit about to fall off the register in the current direction.
  assign bus.so          = bus.dir ? po_q[0] : po_q[WIDTH-1];
  assign bus.po          = po_q;
  assign bus.bit_cnt     = bit_cnt_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
endmodule
